// File: rtl/uart_prog_loader.sv
// Boot-time program loader: receives a framed image over UART (8N1), writes it into the
// CPU instruction memory and holds the CPU in reset until a checksum-valid image is loaded.
module uart_prog_loader #(
    parameter int          CLK_HZ    = 50000000,
    parameter int          BAUD      = 115200,
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, GET_COUNT, GET_DATA, GET_CSUM, DONE, ERROR} state_t;

    logic [1:0]        sync_q, sync_d;
    logic              rx_prev_q, rx_prev_d;
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_bit;
    logic              byte_valid;
    logic              frame_err;

    state_t            state_q, state_d;
    logic [8:0]        count_q, count_d;
    logic [8:0]        word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        acc_q, acc_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;

    assign rx_bit = sync_q[1];

    // Byte receiver: mid-bit sampling counted from the synchronized falling edge of the start bit.
    always_comb begin
        sync_d     = {sync_q[0], uart_rx};
        rx_prev_d  = rx_bit;
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_bit) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (bit_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_bit, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    byte_valid = rx_bit;
                    frame_err  = !rx_bit;
                    rx_state_d = RX_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame FSM. The write strobe cycle stays in GET_DATA; the word counter advances on it.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        asm_d      = asm_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (byte_valid && shift_q == SYNC_BYTE) begin
                    state_d    = GET_COUNT;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    acc_d      = '0;
                end
            end
            GET_COUNT: begin
                if (frame_err) begin
                    state_d = ERROR;
                end else if (byte_valid) begin
                    count_d = (shift_q == 8'h00) ? 9'd256 : {1'b0, shift_q};
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (frame_err) begin
                    state_d = ERROR;
                end else if (mem_we_q) begin
                    word_cnt_d = word_cnt_q + 9'd1;
                    if (word_cnt_q + 9'd1 == count_q) begin
                        state_d = GET_CSUM;
                    end
                end else if (byte_valid) begin
                    acc_d = acc_q ^ shift_q;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d   = 1'b1;
                        mem_data_d = {asm_q, shift_q};
                        mem_addr_d = word_cnt_q[ADDR_W-1:0];
                        byte_idx_d = '0;
                    end else begin
                        asm_d      = {asm_q[15:0], shift_q};
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            GET_CSUM: begin
                if (frame_err) begin
                    state_d = ERROR;
                end else if (byte_valid) begin
                    state_d = (shift_q == acc_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            acc_q      <= '0;
            asm_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            asm_q      <= asm_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign busy     = (state_q == GET_COUNT) || (state_q == GET_DATA) || (state_q == GET_CSUM);
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERROR);
    assign cpu_hold = (state_q != DONE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: randomized frames are serialized onto uart_rx, expected
// memory writes are queued from a word-level image model and checked by an independent monitor.
module tb_uart_prog_loader;

    // Short bit period (4 clocks, truncated from 4.44) keeps the 256-word image well inside the cycle budget
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 225;
    localparam int ADDR_W = 8;
    localparam int CPB    = CLK_HZ / BAUD;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_we;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[256];
    int          checks = 0;
    int          errors = 0;

    uart_prog_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_rx(uart_rx),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected write: addr %h data %h expected none", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check_val("write addr", 32'(mem_addr), 32'(e.addr));
                    check_val("write data", mem_data, e.data);
                end
                check_val("busy during write", 32'(busy), 32'd1);
            end
        end
    end

    function automatic logic [7:0] rand_no_sync();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hA5);
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    // Sends a full frame of words[0..n-1]; every word is expected to be written even if the checksum is bad
    task automatic applyStimulus(input int n, input bit bad_csum, input bit glitch);
        logic [7:0] csum;
        logic [7:0] b;
        csum = 8'h00;
        for (int i = 0; i < n; i++) exp_q.push_back({8'(i), words[i]});
        send_byte(8'hA5, 1'b0);
        send_byte((n == 256) ? 8'h00 : 8'(n), 1'b0);
        if (glitch) begin
            uart_rx = 1'b0;
            @(negedge clk);
            uart_rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = words[i][8*k +: 8];
                csum = csum ^ b;
                send_byte(b, 1'b0);
            end
        end
        send_byte(bad_csum ? ~csum : csum, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input bit exp_done, input bit exp_err,
                               input bit exp_hold, input bit exp_busy);
        check_val({tag, " done"}, 32'(done), 32'(exp_done));
        check_val({tag, " error"}, 32'(error), 32'(exp_err));
        check_val({tag, " cpu_hold"}, 32'(cpu_hold), 32'(exp_hold));
        check_val({tag, " busy"}, 32'(busy), 32'(exp_busy));
        check_val({tag, " pending writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        bit bad;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("reset mem_we", 32'(mem_we), 32'd0);
        check_val("reset mem_addr", 32'(mem_addr), 32'd0);
        check_val("reset mem_data", mem_data, 32'd0);

        repeat (200) @(negedge clk);
        checkOutput("idle line", 1'b0, 1'b0, 1'b1, 1'b0);

        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
        applyStimulus(2, 1'b0, 1'b0);
        checkOutput("two words", 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(2, 1'b1, 1'b0);
        checkOutput("bad checksum", 1'b0, 1'b1, 1'b1, 1'b0);
        fill_random(3);
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("recovery", 1'b1, 1'b0, 1'b0, 1'b0);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(rand_no_sync(), 1'b0);
        send_byte(rand_no_sync(), 1'b0);
        send_byte(rand_no_sync(), 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("framing error", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(rand_no_sync(), 1'b0);
        checkOutput("framing tail", 1'b0, 1'b1, 1'b1, 1'b0);

        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        checkOutput("leading bytes", 1'b0, 1'b1, 1'b1, 1'b0);
        words[0] = 32'h00000001;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("single word", 1'b1, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 6);
            bad = 1'($urandom_range(0, 1));
            fill_random(n);
            applyStimulus(n, bad, 1'b0);
            checkOutput("random frame", !bad, bad, bad, 1'b0);
        end

        words[0] = 32'hCAFEF00D;
        words[1] = 32'h0BADC0DE;
        exp_q.push_back({8'd0, words[0]});
        exp_q.push_back({8'd1, words[1]});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 2; i++)
            for (int k = 3; k >= 0; k--) send_byte(words[i][8*k +: 8], 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("mid frame", 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid-frame reset", 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("mid-frame reset mem_addr", 32'(mem_addr), 32'd0);
        check_val("mid-frame reset mem_data", mem_data, 32'd0);
        check_val("mid-frame reset mem_we", 32'(mem_we), 32'd0);

        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("low pulse", 1'b0, 1'b0, 1'b1, 1'b0);

        fill_random(256);
        applyStimulus(256, 1'b0, 1'b1);
        checkOutput("full image", 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("full image last addr", 32'(mem_addr), 32'd255);
        check_val("full image last data", mem_data, words[255]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
